mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single 16-bit, byte-addressed memory port between two requesters.
- Port 0 is the CPU control unit (instruction fetch and load/store). Port 1 is an auxiliary master (program loader or debug).
- Sequences byte stores as a registered read-modify-write (RMW), so requesters never merge words themselves.
- Sits between the requesters and the memory array. The memory has combinational read and writes on the rising clock edge when mem_we=1.

Parameters:
- FIXED_PRIO, 1, 1 = port 0 has priority with an anti-starvation override; 0 = strict round-robin.
- STARVE_LIMIT, 4, consecutive port-0 grants while port 1 waits before port 1 is forced next (FIXED_PRIO=1 only); range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0, req1  in  1  access request; held with its fields stable until the matching gnt
- we0, we1  in  1  1 = write
- word0, word1  in  1  1 = 16-bit word access (addr[0] ignored); 0 = byte access selected by addr[0]
- addr0, addr1  in  16  byte address
- wdata0, wdata1  in  16  write data; byte access uses [7:0]
- gnt0, gnt1  out  1  one-cycle pulse; the access completes in this cycle
- rdata0, rdata1  out  16  read data, valid only with gnt; byte read = {8'h00, byte}
- mem_addr  out  16  memory word address, {addr[15:1], 1'b0}
- mem_in  out  16  memory write data
- mem_we  out  1  memory write enable
- mem_out  in  16  memory read data (combinational)

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; gnt0=gnt1=0; mem_we=0; mem_addr=0; mem_in=0.
  - Round-robin pointer favours port 0; starve counter=0.
  - A byte write caught mid-RMW is aborted: no memory write, no gnt.
- States:
  - IDLE: arbitrate among asserted reqs.
  - RMW_RD: latched byte write; memory addressed and old word captured into merge_q.
  - RMW_WR: mem_we=1 with the merged word; gnt to the owner.
- Arbitration (IDLE only, one winner per cycle):
  - FIXED_PRIO=0: on a tie the winner is the port not granted last.
  - FIXED_PRIO=1: port 0 wins ties unless starve_cnt==STARVE_LIMIT, then port 1 wins.
  - starve_cnt increments on each port-0 grant while req1 is held.
  - starve_cnt clears on any port-1 grant or when req1=0. It saturates at STARVE_LIMIT.
- Single-cycle accesses (word read, byte read, word write):
  - Served in IDLE in the winning cycle; state stays IDLE.
  - mem_addr and mem_in are combinational from the winner; mem_we=we for word writes.
  - gnt and rdata are registered, asserted the following cycle.
  - The winner must deassert req the cycle gnt is seen, or it is treated as a new request.
  - Throughput is one access every 2 cycles per port; back-to-back accesses from alternate ports are allowed.
- Byte write:
  - IDLE latches owner, address, wdata[7:0] and addr[0], then goes to RMW_RD.
  - RMW_RD captures mem_out into merge_q, then goes to RMW_WR.
  - RMW_WR drives mem_in = merge_q with the selected byte replaced, mem_we=1, and a registered gnt next cycle, then returns to IDLE.
  - Latency is 3 cycles from win to gnt.
  - The other port is blocked for the whole sequence, so the RMW is atomic.
- No request: mem_we=0, mem_addr held at its last value, no gnt.
- Never more than one gnt per cycle. mem_we is never 1 in IDLE for byte writes.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, RMW_RD, RMW_WR};
  - constants MEM_W=16, BYTE_W=8;
  - function merge_byte(word, byte, sel).
- One sub-module, rr_pick: two-input arbiter holding the round-robin pointer and starve counter; outputs the one-hot winner.

Test Plan:
- Reset, then req0 word read addr=0x0010 with memory holding 0xBEEF at 0x0010 -> mem_addr=0x0010, next cycle gnt0=1, rdata0=0xBEEF.
- Both ports request reads continuously with FIXED_PRIO=1, STARVE_LIMIT=4 -> grants go 0,0,0,0,1,0,0,0,0,1; gnt1 is never skipped past 4.
- req1 byte write addr=0x0021, wdata=0x005A, old word 0x1234 -> RMW_RD then RMW_WR with mem_in=0x5A34, mem_we for exactly one cycle, gnt1 3 cycles after the win; req0 is stalled throughout.
- FIXED_PRIO=0, both ports requesting -> strict alternation 0,1,0,1 starting with port 0 after reset.
- rst asserted in the RMW_RD cycle of a byte write -> no mem_we, no gnt; memory word unchanged; state IDLE next cycle.
- Byte read addr=0x0031 with word 0xA1B2 -> rdata=0x00A1. Word write with odd addr=0x0041 -> mem_addr=0x0040.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
package mem_pkg;

  localparam int unsigned MEM_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  typedef struct packed {
    logic             we;
    logic             word;
    logic [MEM_W-1:0] addr;
    logic [MEM_W-1:0] wdata;
  } mem_req_t;

  // Replace one byte of a word; sel=1 selects the upper byte (odd address).
  function automatic logic [MEM_W-1:0] merge_byte(input logic [MEM_W-1:0]  word,
                                                  input logic [BYTE_W-1:0] byte_val,
                                                  input logic              sel);
    logic [MEM_W-1:0] res;
    res = word;
    if (sel) res[MEM_W-1:BYTE_W] = byte_val;
    else     res[BYTE_W-1:0]     = byte_val;
    return res;
  endfunction

  // Zero-extended byte read of a word.
  function automatic logic [MEM_W-1:0] extract_byte(input logic [MEM_W-1:0] word,
                                                    input logic             sel);
    logic [BYTE_W-1:0] b;
    b = sel ? word[MEM_W-1:BYTE_W] : word[BYTE_W-1:0];
    return MEM_W'(b);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Two-input arbiter: round-robin pointer or fixed priority with a starvation override.
module rr_pick #(
  parameter bit          FIXED_PRIO   = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       req0,
  input  logic       req1,
  output logic [1:0] win_c
);

  localparam int unsigned CNT_W = 4;

  logic             last1_q;  // 1 = port 1 won most recently
  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved = (starve_q == CNT_W'(STARVE_LIMIT));

  always_comb begin
    win_c = 2'b00;
    if (en) begin
      if (req0 && req1) begin
        if (FIXED_PRIO) win_c = starved ? 2'b10 : 2'b01;
        else            win_c = last1_q ? 2'b01 : 2'b10;
      end else if (req0) begin
        win_c = 2'b01;
      end else if (req1) begin
        win_c = 2'b10;
      end
    end
  end

  // Pointer starts favouring port 0; starve count tracks port-0 wins while port 1 waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      last1_q  <= 1'b1;
      starve_q <= '0;
    end else begin
      if (win_c[0])      last1_q <= 1'b0;
      else if (win_c[1]) last1_q <= 1'b1;

      if (!req1 || win_c[1])          starve_q <= '0;
      else if (win_c[0] && !starved)  starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 16-bit byte-addressed memory port between two requesters,
// sequencing byte stores as an atomic registered read-modify-write.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter bit          FIXED_PRIO   = 1'b1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic             word0,
  input  logic             word1,
  input  logic [MEM_W-1:0] addr0,
  input  logic [MEM_W-1:0] addr1,
  input  logic [MEM_W-1:0] wdata0,
  input  logic [MEM_W-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [MEM_W-1:0] rdata0,
  output logic [MEM_W-1:0] rdata1,
  output logic [MEM_W-1:0] mem_addr,
  output logic [MEM_W-1:0] mem_in,
  output logic             mem_we,
  input  logic [MEM_W-1:0] mem_out
);

  state_e state_q, state_d;

  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic [MEM_W-1:0]  rdata0_q, rdata0_d;
  logic [MEM_W-1:0]  rdata1_q, rdata1_d;
  logic              own_q, own_d;
  logic [MEM_W-1:0]  baddr_q, baddr_d;
  logic [BYTE_W-1:0] bdata_q, bdata_d;
  logic              bsel_q, bsel_d;
  logic [MEM_W-1:0]  merge_q, merge_d;
  logic [MEM_W-1:0]  mem_addr_q;
  logic [MEM_W-1:0]  mem_in_q;

  mem_req_t   r0, r1, wreq;
  logic [1:0] win_c;
  logic [MEM_W-1:0] rd_val;

  assign r0 = '{we: we0, word: word0, addr: addr0, wdata: wdata0};
  assign r1 = '{we: we1, word: word1, addr: addr1, wdata: wdata1};

  rr_pick #(
    .FIXED_PRIO   (FIXED_PRIO),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .clk   (clk),
    .rst   (rst),
    .en    ((state_q == IDLE) && !rst),
    .req0  (req0),
    .req1  (req1),
    .win_c (win_c)
  );

  assign wreq   = win_c[1] ? r1 : r0;
  assign rd_val = wreq.word ? mem_out : extract_byte(mem_out, wreq.addr[0]);

  always_comb begin
    state_d  = state_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    own_d    = own_q;
    baddr_d  = baddr_q;
    bdata_d  = bdata_q;
    bsel_d   = bsel_q;
    merge_d  = merge_q;
    mem_addr = mem_addr_q;
    mem_in   = mem_in_q;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (win_c != 2'b00) begin
          mem_addr = {wreq.addr[MEM_W-1:1], 1'b0};
          if (wreq.we && !wreq.word) begin
            // Byte store: latch everything so the requester fields may change after gnt.
            own_d   = win_c[1];
            baddr_d = {wreq.addr[MEM_W-1:1], 1'b0};
            bdata_d = wreq.wdata[BYTE_W-1:0];
            bsel_d  = wreq.addr[0];
            state_d = RMW_RD;
          end else begin
            if (wreq.we) begin
              mem_in = wreq.wdata;
              mem_we = 1'b1;
            end
            if (win_c[1]) begin
              gnt1_d   = 1'b1;
              rdata1_d = rd_val;
            end else begin
              gnt0_d   = 1'b1;
              rdata0_d = rd_val;
            end
          end
        end
      end
      RMW_RD: begin
        mem_addr = baddr_q;
        merge_d  = mem_out;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        mem_addr = baddr_q;
        mem_in   = merge_byte(merge_q, bdata_q, bsel_q);
        mem_we   = 1'b1;
        gnt0_d   = !own_q;
        gnt1_d   = own_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A reset cycle never commits a memory write.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      own_q      <= 1'b0;
      baddr_q    <= '0;
      bdata_q    <= '0;
      bsel_q     <= 1'b0;
      merge_q    <= '0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      own_q      <= own_d;
      baddr_q    <= baddr_d;
      bdata_q    <= bdata_d;
      bsel_q     <= bsel_d;
      merge_q    <= merge_d;
      mem_addr_q <= mem_addr;
      mem_in_q   <= mem_in;
    end
  end

  assign gnt0   = gnt0_q;
  assign gnt1   = gnt1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority instance and a round-robin
// instance share stimulus, each with its own behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, we0, we1, word0, word1;
  logic [15:0] addr0, addr1, wdata0, wdata1;

  logic        gnt0_a, gnt1_a, mem_we_a;
  logic [15:0] rdata0_a, rdata1_a, mem_addr_a, mem_in_a, mem_out_a;
  logic        gnt0_b, gnt1_b, mem_we_b;
  logic [15:0] rdata0_b, rdata1_b, mem_addr_b, mem_in_b, mem_out_b;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic        tb_wr;
  logic [15:0] tb_wa, tb_wd;

  int n_cmp = 0;
  int n_err = 0;

  mem_arbiter #(.FIXED_PRIO(1'b1), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .word0(word0), .word1(word1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_a), .gnt1(gnt1_a), .rdata0(rdata0_a), .rdata1(rdata1_a),
    .mem_addr(mem_addr_a), .mem_in(mem_in_a), .mem_we(mem_we_a), .mem_out(mem_out_a)
  );

  mem_arbiter #(.FIXED_PRIO(1'b0), .STARVE_LIMIT(4)) dut_b (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .word0(word0), .word1(word1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0_b), .gnt1(gnt1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
    .mem_addr(mem_addr_b), .mem_in(mem_in_b), .mem_we(mem_we_b), .mem_out(mem_out_b)
  );

  assign mem_out_a = mem_a[mem_addr_a[8:1]];
  assign mem_out_b = mem_b[mem_addr_b[8:1]];

  always @(posedge clk) begin
    if (tb_wr) begin
      mem_a[tb_wa[8:1]] <= tb_wd;
      mem_b[tb_wa[8:1]] <= tb_wd;
    end else begin
      if (mem_we_a) mem_a[mem_addr_a[8:1]] <= mem_in_a;
      if (mem_we_b) mem_b[mem_addr_b[8:1]] <= mem_in_b;
    end
  end

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we, input bit wd,
                       input logic [15:0] a, input logic [15:0] d);
    if (!p) begin
      req0 = r; we0 = we; word0 = wd; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; word1 = wd; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    tb_wr = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk);
    #1 tb_wr = 1'b0;
  endtask

  typedef struct {
    string       name;
    bit          port;
    bit          we;
    bit          word;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] init;
    logic [15:0] exp_maddr;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"wrd_rd_p0",   1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, 16'hBEEF, 16'h0010, 16'hBEEF};
    vecs[1] = '{"byte_rd_hi",  1'b0, 1'b0, 1'b0, 16'h0031, 16'h0000, 16'hA1B2, 16'h0030, 16'h00A1};
    vecs[2] = '{"byte_rd_lo",  1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 16'hA1B2, 16'h0030, 16'h00B2};
    vecs[3] = '{"wrd_wr_odd",  1'b0, 1'b1, 1'b1, 16'h0041, 16'hCAFE, 16'h0000, 16'h0040, 16'h0000};
    vecs[4] = '{"wrd_wr_p1",   1'b1, 1'b1, 1'b1, 16'h0060, 16'h1357, 16'hFFFF, 16'h0060, 16'h0000};
    vecs[5] = '{"wrd_rd_p1",   1'b1, 1'b0, 1'b1, 16'h0063, 16'h0000, 16'h7788, 16'h0062, 16'h7788};

    tb_wr = 1'b0; tb_wa = '0; tb_wd = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1 ("rst_gnt0",  gnt0_a, 1'b0);
    chk1 ("rst_gnt1",  gnt1_a, 1'b0);
    chk1 ("rst_we",    mem_we_a, 1'b0);
    chk16("rst_addr",  mem_addr_a, 16'h0000);
    chk16("rst_in",    mem_in_a, 16'h0000);

    // Single-cycle accesses from the vector table.
    for (int i = 0; i < 6; i++) begin
      preload(vecs[i].addr, vecs[i].init);
      drive(vecs[i].port, 1'b1, vecs[i].we, vecs[i].word, vecs[i].addr, vecs[i].wdata);
      @(negedge clk);
      chk16({vecs[i].name, "_maddr"}, mem_addr_a, vecs[i].exp_maddr);
      chk1 ({vecs[i].name, "_we"}, mem_we_a, vecs[i].we);
      if (vecs[i].we) chk16({vecs[i].name, "_min"}, mem_in_a, vecs[i].wdata);
      chk1 ({vecs[i].name, "_early_gnt"}, vecs[i].port ? gnt1_a : gnt0_a, 1'b0);
      @(posedge clk);
      #1 drive(vecs[i].port, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge clk);
      chk1({vecs[i].name, "_gnt"}, vecs[i].port ? gnt1_a : gnt0_a, 1'b1);
      chk1({vecs[i].name, "_other"}, vecs[i].port ? gnt0_a : gnt1_a, 1'b0);
      chk1({vecs[i].name, "_we_off"}, mem_we_a, 1'b0);
      if (vecs[i].we)
        chk16({vecs[i].name, "_mem"}, mem_a[vecs[i].addr[8:1]], vecs[i].wdata);
      else
        chk16({vecs[i].name, "_rdata"}, vecs[i].port ? rdata1_a : rdata0_a, vecs[i].exp_rdata);
    end

    // Byte write from port 1 with port 0 arriving mid-sequence.
    preload(16'h0020, 16'h1234);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0021, 16'h005A);
    @(negedge clk);
    chk1 ("rmw_win_we",   mem_we_a, 1'b0);
    chk16("rmw_win_addr", mem_addr_a, 16'h0020);
    @(posedge clk);
    #1 drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    @(negedge clk);
    chk1 ("rmw_rd_we",   mem_we_a, 1'b0);
    chk16("rmw_rd_addr", mem_addr_a, 16'h0020);
    chk1 ("rmw_rd_gnt0", gnt0_a, 1'b0);
    chk1 ("rmw_rd_gnt1", gnt1_a, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk1 ("rmw_wr_we",   mem_we_a, 1'b1);
    chk16("rmw_wr_in",   mem_in_a, 16'h5A34);
    chk16("rmw_wr_addr", mem_addr_a, 16'h0020);
    chk1 ("rmw_wr_gnt0", gnt0_a, 1'b0);
    chk1 ("rmw_wr_gnt1", gnt1_a, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1 ("rmw_gnt1",     gnt1_a, 1'b1);
    chk1 ("rmw_gnt0_off", gnt0_a, 1'b0);
    chk1 ("rmw_done_we",  mem_we_a, 1'b0);
    chk16("rmw_mem",      mem_a[8'h10], 16'h5A34);
    chk16("rmw_p0_addr",  mem_addr_a, 16'h0010);
    @(posedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1 ("stall_gnt0",  gnt0_a, 1'b1);
    chk1 ("stall_gnt1",  gnt1_a, 1'b0);
    chk16("stall_rdata", rdata0_a, 16'hBEEF);

    // Reset during the read phase of a byte write aborts it.
    preload(16'h0050, 16'h1111);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0050, 16'h00EE);
    @(negedge clk);
    chk1("abort_win_we", mem_we_a, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1("abort_rd_we", mem_we_a, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0050, 16'h0000);
    @(negedge clk);
    chk1 ("abort_we",   mem_we_a, 1'b0);
    chk1 ("abort_gnt0", gnt0_a, 1'b0);
    chk1 ("abort_gnt1", gnt1_a, 1'b0);
    chk16("abort_addr", mem_addr_a, 16'h0050);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    chk1 ("abort_rd_gnt1", gnt1_a, 1'b1);
    chk1 ("abort_rd_gnt0", gnt0_a, 1'b0);
    chk16("abort_rd_data", rdata1_a, 16'h1111);
    chk16("abort_mem",     mem_a[8'h28], 16'h1111);

    // Continuous contention: fixed priority with starvation limit vs round-robin.
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'h0010, 16'h0000);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      bit exp_a1;
      bit exp_b1;
      exp_a1 = (k == 4) || (k == 9);
      exp_b1 = (k % 2) == 1;
      @(posedge clk);
      #1;
      if (k == 9) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      end
      @(negedge clk);
      chk1($sformatf("prio_g1_%0d", k), gnt1_a, exp_a1);
      chk1($sformatf("prio_g0_%0d", k), gnt0_a, !exp_a1);
      chk1($sformatf("rr_g1_%0d", k),   gnt1_b, exp_b1);
      chk1($sformatf("rr_g0_%0d", k),   gnt0_b, !exp_b1);
    end
    @(posedge clk);
    @(negedge clk);
    chk1("idle_gnt0", gnt0_a, 1'b0);
    chk1("idle_gnt1", gnt1_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
